// File: rtl/cdc_hsk_sender.sv
// Source-side four-phase request/acknowledge driver feeding a handshake synchronizer.
// Optional handshake watchdog is compiled in when CDC_HSK_SENDER_TIMEOUT_EN is defined.
`timescale 1ns/1ps
module cdc_hsk_sender #(
    parameter int WIDTH          = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             src_clk,
    input  logic             src_rst,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] src_in,
    output logic             src_send,
    input  logic             src_rcv,
    output logic             busy,
    output logic [31:0]      sent_count,
    output logic             timeout_err
);

    localparam logic [1:0] IDLE         = 2'd0;
    localparam logic [1:0] SEND         = 2'd1;
    localparam logic [1:0] WAIT_RCV_LOW = 2'd2;

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             hold_valid;
    logic [WIDTH-1:0] hold_data;
    logic             load;
    logic             accept;
    logic             hsk_done;

    assign load     = hold_valid && (state == IDLE);
    assign s_ready  = !hold_valid || load;
    assign accept   = s_valid && s_ready;
    assign hsk_done = (state == WAIT_RCV_LOW) && !src_rcv;
    assign busy     = hold_valid || (state != IDLE);

    // Holding register: refilled in the same cycle it drains into src_in.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_valid <= 1'b1;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge src_clk) begin
        if (accept) begin
            hold_data <= s_data;
        end
    end

    // src_rcv is only looked at in SEND and WAIT_RCV_LOW.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:         if (load)     state_nxt = SEND;
            SEND:         if (src_rcv)  state_nxt = WAIT_RCV_LOW;
            WAIT_RCV_LOW: if (!src_rcv) state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            state    <= IDLE;
            src_send <= 1'b0;
            src_in   <= '0;
        end else begin
            state    <= state_nxt;
            src_send <= (state_nxt == SEND);
            if (load) begin
                src_in <= hold_data;
            end
        end
    end

    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            sent_count <= 32'd0;
        end else if (hsk_done) begin
            sent_count <= sent_count + 32'd1;
        end
    end

`ifdef CDC_HSK_SENDER_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

    logic [31:0] hsk_cycles;
    logic        in_hsk;

    assign in_hsk = (state != IDLE);

    // Counter saturates at the limit so a stuck handshake cannot wrap it.
    always_ff @(posedge src_clk or posedge src_rst) begin
        if (src_rst) begin
            hsk_cycles  <= 32'd0;
            timeout_err <= 1'b0;
        end else begin
            if (load) begin
                hsk_cycles <= 32'd0;
            end else if (in_hsk && (hsk_cycles != TIMEOUT_LIMIT)) begin
                hsk_cycles <= hsk_cycles + 32'd1;
            end
            if (in_hsk && (hsk_cycles + 32'd1 == TIMEOUT_LIMIT)) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    // No watchdog: the threshold only matters when the counter exists.
    assign timeout_err = (TIMEOUT_CYCLES < 0) && 1'b0;
`endif

endmodule

// File: tb/tb_cdc_hsk_sender.sv
// Directed bench for cdc_hsk_sender: single word, back-to-back, early ack, reset, timeout, wrap.
`timescale 1ns/1ps
module tb_cdc_hsk_sender;

    logic        src_clk;
    logic        src_rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] src_in;
    logic        src_send;
    logic        src_rcv;
    logic        busy;
    logic [31:0] sent_count;
    logic        timeout_err;

    int tests;
    int failures;

    cdc_hsk_sender #(
        .WIDTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .src_clk(src_clk),
        .src_rst(src_rst),
        .s_data(s_data),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .src_in(src_in),
        .src_send(src_send),
        .src_rcv(src_rcv),
        .busy(busy),
        .sent_count(sent_count),
        .timeout_err(timeout_err)
    );

    initial src_clk = 1'b0;
    always #5 src_clk = ~src_clk;

    task automatic tick();
        @(posedge src_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        src_rst = 1'b1;
        s_valid = 1'b0;
        src_rcv = 1'b0;
        tick();
        tick();
        src_rst = 1'b0;
        tick();
    endtask

    // One word through an idle block; acknowledge rises/falls after the given delays.
    task automatic do_word(input logic [15:0] d, input int rise_dly, input int fall_dly);
        s_data  = d;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        check("word_held_busy", busy, 1'b1);
        tick();
        check("word_send_up", src_send, 1'b1);
        check("word_src_in", src_in, d);
        for (int i = 1; i < rise_dly; i++) begin
            tick();
            check("word_send_hold", src_send, 1'b1);
            check("word_src_in_send", src_in, d);
        end
        src_rcv = 1'b1;
        tick();
        check("word_send_down", src_send, 1'b0);
        check("word_src_in_ack", src_in, d);
        for (int i = 1; i < fall_dly; i++) begin
            tick();
            check("word_wait_busy", busy, 1'b1);
            check("word_src_in_wait", src_in, d);
        end
        src_rcv = 1'b0;
        tick();
        check("word_idle_busy", busy, 1'b0);
        check("word_src_in_after", src_in, d);
    endtask

    initial begin
        int idx;
        int got;
        int last_rise;
        int stalls;
        logic acc;
        logic prev_send;
        logic seen_send;
        logic exp_to;

        tests    = 0;
        failures = 0;
        s_data   = 16'h0;

`ifdef CDC_HSK_SENDER_TIMEOUT_EN
        exp_to = 1'b1;
`else
        exp_to = 1'b0;
`endif

        // Reset state
        src_rst = 1'b1;
        s_valid = 1'b0;
        src_rcv = 1'b0;
        tick();
        tick();
        check("rst_send", src_send, 1'b0);
        check("rst_src_in", src_in, 16'h0);
        check("rst_count", sent_count, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_timeout", timeout_err, 1'b0);
        src_rst = 1'b0;
        tick();
        check("rst_ready", s_ready, 1'b1);

        // Single word with slow acknowledge
        do_word(16'hA5A5, 4, 4);
        check("single_count", sent_count, 32'd1);

        // Back-to-back words 0..7, acknowledge mirrors src_send one cycle later
        do_reset();
        s_data    = 16'h0;
        s_valid   = 1'b1;
        idx       = 0;
        got       = 0;
        last_rise = 0;
        stalls    = 0;
        prev_send = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            acc = s_valid && s_ready;
            tick();
            if (acc) begin
                idx++;
                if (idx == 8) s_valid = 1'b0;
                s_data = 16'(idx);
            end
            if (src_send && !prev_send) begin
                check("b2b_order", src_in, 32'(got));
                if (got > 0) check("b2b_period", 32'(c - last_rise), 32'd3);
                last_rise = c;
                got++;
            end
            if (busy && !s_ready) stalls++;
            prev_send = src_send;
            src_rcv   = src_send;
            if (got == 8 && !busy) break;
        end
        check("b2b_words", 32'(got), 32'd8);
        check("b2b_count", sent_count, 32'd8);
        check("b2b_stalled", 32'(stalls > 0), 32'd1);
        check("b2b_idle", busy, 1'b0);

        // Acknowledge pulsed while idle must be ignored
        do_reset();
        src_rcv = 1'b1;
        tick();
        tick();
        check("early_send", src_send, 1'b0);
        check("early_busy", busy, 1'b0);
        check("early_count", sent_count, 32'd0);
        src_rcv = 1'b0;
        tick();
        do_word(16'h1234, 1, 1);
        check("early_count_after", sent_count, 32'd1);

        // Reset during SEND with a second word held
        do_reset();
        s_data  = 16'hBEEF;
        s_valid = 1'b1;
        tick();
        s_data = 16'hCAFE;
        tick();
        s_valid = 1'b0;
        check("mid_send", src_send, 1'b1);
        check("mid_src_in", src_in, 16'hBEEF);
        check("mid_ready_full", s_ready, 1'b0);
        #3;
        src_rst = 1'b1;
        #1;
        check("mid_send_async", src_send, 1'b0);
        check("mid_src_in_async", src_in, 16'h0);
        check("mid_busy_async", busy, 1'b0);
        check("mid_count", sent_count, 32'd0);
        tick();
        src_rst   = 1'b0;
        seen_send = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (src_send) seen_send = 1'b1;
            src_rcv = src_send;
        end
        src_rcv = 1'b0;
        check("mid_never_sent", seen_send, 1'b0);
        check("mid_ready_after", s_ready, 1'b1);
        check("mid_count_after", sent_count, 32'd0);

        // Watchdog: acknowledge withheld past the threshold
        do_reset();
        s_data  = 16'h5A5A;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        tick();
        check("to_send_entry", src_send, 1'b1);
        repeat (15) tick();
        check("to_not_yet", timeout_err, 1'b0);
        tick();
        check("to_flag", timeout_err, exp_to);
        check("to_send_held", src_send, 1'b1);
        src_rcv = 1'b1;
        tick();
        src_rcv = 1'b0;
        tick();
        check("to_count", sent_count, 32'd1);
        check("to_sticky", timeout_err, exp_to);
        check("to_idle", busy, 1'b0);

        // sent_count wraps from all-ones to zero
        force dut.sent_count = 32'hFFFF_FFFF;
        #1;
        release dut.sent_count;
        #1;
        check("wrap_preload", sent_count, 32'hFFFF_FFFF);
        do_word(16'h0F0F, 1, 1);
        check("wrap_zero", sent_count, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule

// File: doc/cdc_hsk_sender.md
CDC_HSK_SENDER -- requirements
Module: cdc_hsk_sender

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width driven to the handshake synchronizer.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024, timeout threshold in cycles (used only when CDC_HSK_SENDER_TIMEOUT_EN is defined).
REQ-003 SHALL have port src_clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port src_rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port s_data  input  WIDTH  upstream word.
REQ-006 SHALL have port s_valid  input  1  upstream word valid.
REQ-007 SHALL have port s_ready  output  1  block accepts s_data this cycle.
REQ-008 SHALL have port src_in  output  WIDTH  word to synchronizer.
REQ-009 SHALL have port src_send  output  1  handshake request to synchronizer.
REQ-010 SHALL have port src_rcv  input  1  handshake acknowledge from synchronizer.
REQ-011 SHALL have port busy  output  1  word held or handshake in progress.
REQ-012 SHALL have port sent_count  output  32  completed handshakes, wraps 2^32-1 -> 0.
REQ-013 SHALL have port timeout_err  output  1  sticky handshake-timeout flag.

Function
REQ-014 SHALL accept a word when s_valid && s_ready into a one-entry holding register (hold_valid, hold_data).
REQ-015 SHALL implement FSM states IDLE, SEND, WAIT_RCV_LOW.
REQ-016 load = hold_valid && state==IDLE; on load SHALL register src_in <= hold_data, src_send <= 1, clear hold_valid, go SEND (src_send high one cycle after load condition).
REQ-017 s_ready SHALL be combinational !hold_valid || load; a word accepted in the load cycle SHALL set hold_valid with no gap.
REQ-018 In SEND, src_send SHALL stay 1 and src_in stable until src_rcv==1 sampled; then src_send <= 0, go WAIT_RCV_LOW.
REQ-019 In WAIT_RCV_LOW, src_in SHALL stay stable; on src_rcv==0 sampled go IDLE and increment sent_count by 1.
REQ-020 src_rcv SHALL be ignored in IDLE; a stuck-high src_rcv SHALL hold the FSM in WAIT_RCV_LOW indefinitely.
REQ-021 busy SHALL equal hold_valid || state!=IDLE.
REQ-022 Back-to-back words SHALL be sent in order, none dropped or duplicated; at most one word held while a handshake is in progress.
REQ-023 Minimum handshake period SHALL be 3 cycles per word given immediate src_rcv response (load, SEND, WAIT_RCV_LOW).

Reset
REQ-024 On src_rst high SHALL asynchronously force: state IDLE, hold_valid 0, src_send 0, src_in 0, sent_count 0, timeout_err 0; s_ready SHALL read 1 after reset release.
REQ-025 Reset mid-handshake SHALL drop src_send immediately and discard held data; the destination side SHALL be reset by the system concurrently.

Configuration
REQ-026 With macro CDC_HSK_SENDER_TIMEOUT_EN defined, a 32-bit counter SHALL clear on entry to SEND, count every cycle in SEND or WAIT_RCV_LOW, and set timeout_err when it reaches TIMEOUT_CYCLES.
REQ-027 timeout_err SHALL remain set until src_rst; timeout SHALL NOT abort or alter the handshake.
REQ-028 Without CDC_HSK_SENDER_TIMEOUT_EN, no counter SHALL be synthesized and timeout_err SHALL be constant 0.

Verification
REQ-029 Single word: s_data=16'hA5A5 valid one cycle, src_rcv rises 4 cycles after src_send, falls 4 cycles after src_send drops -> src_in=A5A5 throughout, sent_count=1, busy low after.
REQ-030 Back-to-back: 8 words 0..7 with s_valid held high, src_rcv responding in 1 cycle -> src_in sequence 0..7 in order, s_ready stalls while hold full, sent_count=8.
REQ-031 Early src_rcv: src_rcv pulsed high in IDLE, then word 16'h1234 sent -> no state change in IDLE, exactly one handshake, sent_count=1.
REQ-032 Reset mid-operation: assert src_rst while in SEND with held word -> src_send=0 same cycle (async), sent_count=0, s_ready=1 after release, held word never sent.
REQ-033 Timeout (macro defined, TIMEOUT_CYCLES=16): src_rcv never rises -> timeout_err=1 16 cycles after SEND entry, src_send still 1; later src_rcv completes -> sent_count=1, timeout_err stays 1. Macro undefined -> timeout_err stays 0.
REQ-034 Counter wrap: preload sent_count to 32'hFFFFFFFF via force, complete one handshake -> sent_count=0.
